sync_debounce_event: RTL and testbench

- Destination-domain stage that sits directly downstream of the multi-flop synchronizer, on dest_clk.
- Takes the synchronized BITWIDTH-bit level and requires each bit to hold a new value for STABLE_CYCLES consecutive clocks before accepting it.
- Emits a filtered level, per-bit rise/fall pulses, and a valid/ready change-event record.
- Event records carry a sticky overflow indication for a stalled consumer.

---
 rtl/sync_debounce_event.sv | 148 ++++++++++++++
 tb/tb_sync_debounce_event.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_event.sv
// sync_debounce_event
// Debounce stage that sits on dest_clk directly after the multi-flop
// synchronizer. Each bit of din must hold a value different from dout for
// STABLE_CYCLES consecutive samples before dout takes it. Every accepted
// change produces a one-cycle rise/fall pulse and is folded into a
// valid/ready change-event record.
//
// Event handshake: evt_valid/evt_value/evt_mask/evt_overflow form a record.
// The consumer takes it on any edge where evt_valid && evt_ready. evt_ready
// has no effect while evt_valid is low. While the record is stalled
// (evt_valid && !evt_ready), its fields stay put unless a new change merges
// in. A merge ORs the new change bits into evt_mask, refreshes evt_value and
// sets evt_overflow. A handshake on the same edge as a new change loads a
// fresh record with no bubble. dout, rise and fall never wait on the consumer.

module sync_debounce_event #(
    parameter int                  BITWIDTH      = 1,
    parameter int                  STABLE_CYCLES = 8,
    parameter logic [BITWIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                dest_clk,
    input  logic                dest_rst,
    input  logic [BITWIDTH-1:0] din,
    output logic [BITWIDTH-1:0] dout,
    output logic [BITWIDTH-1:0] rise,
    output logic [BITWIDTH-1:0] fall,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [BITWIDTH-1:0] evt_value,
    output logic [BITWIDTH-1:0] evt_mask,
    output logic                evt_overflow
);

    // Counter wide enough to hold 0..STABLE_CYCLES.
    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    // Registered state
    logic [CW-1:0]       r_cnt [BITWIDTH];
    logic [BITWIDTH-1:0] r_dout;
    logic [BITWIDTH-1:0] r_rise;
    logic [BITWIDTH-1:0] r_fall;
    logic                r_evt_valid;
    logic [BITWIDTH-1:0] r_evt_value;
    logic [BITWIDTH-1:0] r_evt_mask;
    logic                r_evt_overflow;

    // Combinational next-state
    logic [CW-1:0]       w_cnt_nxt [BITWIDTH];
    logic [BITWIDTH-1:0] w_chg;
    logic [BITWIDTH-1:0] w_dout_nxt;
    logic                w_any_chg;
    logic                w_hs;
    logic                w_load;
    logic                w_merge;
    logic                w_drain;

    // Per-bit qualification: count consecutive samples that differ from dout.
    // A sample that matches dout restarts the count. The sample that would
    // reach STABLE_CYCLES accepts the new value instead.
    always_comb begin
        w_chg = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (din[i] != r_dout[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_chg[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Next debounced level: changed bits take din, others keep dout.
    always_comb begin
        w_dout_nxt = (r_dout & ~w_chg) | (din & w_chg);
    end

    // Event record control decode.
    always_comb begin
        w_any_chg = |w_chg;
        w_hs      = r_evt_valid & evt_ready;
        w_load    = w_any_chg & (~r_evt_valid | w_hs);
        w_merge   = w_any_chg & r_evt_valid & ~evt_ready;
        w_drain   = w_hs & ~w_any_chg;
    end

    // Debounce counters and filtered level.
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            for (int i = 0; i < BITWIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            r_dout <= RESET_VALUE;
        end else begin
            for (int i = 0; i < BITWIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_dout <= w_dout_nxt;
        end
    end

    // Edge pulses, registered so they line up with the dout update.
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_chg & din;
            r_fall <= w_chg & ~din;
        end
    end

    // Change-event record: load, merge under backpressure, or drain.
    always_ff @(posedge dest_clk or posedge dest_rst) begin
        if (dest_rst) begin
            r_evt_valid    <= 1'b0;
            r_evt_value    <= '0;
            r_evt_mask     <= '0;
            r_evt_overflow <= 1'b0;
        end else if (w_load) begin
            r_evt_valid    <= 1'b1;
            r_evt_value    <= w_dout_nxt;
            r_evt_mask     <= w_chg;
            r_evt_overflow <= 1'b0;
        end else if (w_merge) begin
            r_evt_value    <= w_dout_nxt;
            r_evt_mask     <= r_evt_mask | w_chg;
            r_evt_overflow <= 1'b1;
        end else if (w_drain) begin
            // evt_value keeps the last delivered level.
            r_evt_valid    <= 1'b0;
            r_evt_mask     <= '0;
            r_evt_overflow <= 1'b0;
        end
    end

    assign dout         = r_dout;
    assign rise         = r_rise;
    assign fall         = r_fall;
    assign evt_valid    = r_evt_valid;
    assign evt_value    = r_evt_value;
    assign evt_mask     = r_evt_mask;
    assign evt_overflow = r_evt_overflow;

endmodule

// File: tb/tb_sync_debounce_event.sv
// Bench for sync_debounce_event. Three instances share din/evt_ready/reset:
// STABLE_CYCLES=8 and 1 with reset value 0, and STABLE_CYCLES=8 with reset
// value 4'hA. A reference model judges a bit as accepted when the last
// STABLE_CYCLES post-reset samples all differ from the modelled level.

module tb_sync_debounce_event;

    localparam int         NI = 3;
    localparam int         S_TAB  [NI] = '{8, 1, 8};
    localparam logic [3:0] RV_TAB [NI] = '{4'h0, 4'h0, 4'hA};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] din = 4'h0;
    logic       ready = 1'b0;

    logic [3:0] o8_dout, o8_rise, o8_fall, o8_value, o8_mask;
    logic       o8_valid, o8_ovf;
    logic [3:0] o1_dout, o1_rise, o1_fall, o1_value, o1_mask;
    logic       o1_valid, o1_ovf;
    logic [3:0] oa_dout, oa_rise, oa_fall, oa_value, oa_mask;
    logic       oa_valid, oa_ovf;

    int vectors = 0;
    int miscompares = 0;
    int rise0_cnt = 0;

    // Reference model state
    logic [3:0] hist [NI][8];
    int         hcnt [NI];
    logic [3:0] m_dout [NI];
    logic [3:0] m_rise [NI];
    logic [3:0] m_fall [NI];
    logic       m_valid [NI];
    logic [3:0] m_value [NI];
    logic [3:0] m_mask [NI];
    logic       m_ovf [NI];

    // Clock
    always #5 clk = ~clk;

    sync_debounce_event #(.BITWIDTH(4), .STABLE_CYCLES(8), .RESET_VALUE(4'h0)) u_s8 (
        .dest_clk(clk), .dest_rst(rst), .din(din), .dout(o8_dout),
        .rise(o8_rise), .fall(o8_fall), .evt_valid(o8_valid), .evt_ready(ready),
        .evt_value(o8_value), .evt_mask(o8_mask), .evt_overflow(o8_ovf)
    );

    sync_debounce_event #(.BITWIDTH(4), .STABLE_CYCLES(1), .RESET_VALUE(4'h0)) u_s1 (
        .dest_clk(clk), .dest_rst(rst), .din(din), .dout(o1_dout),
        .rise(o1_rise), .fall(o1_fall), .evt_valid(o1_valid), .evt_ready(ready),
        .evt_value(o1_value), .evt_mask(o1_mask), .evt_overflow(o1_ovf)
    );

    sync_debounce_event #(.BITWIDTH(4), .STABLE_CYCLES(8), .RESET_VALUE(4'hA)) u_sa (
        .dest_clk(clk), .dest_rst(rst), .din(din), .dout(oa_dout),
        .rise(oa_rise), .fall(oa_fall), .evt_valid(oa_valid), .evt_ready(ready),
        .evt_value(oa_value), .evt_mask(oa_mask), .evt_overflow(oa_ovf)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int m);
        hcnt[m]    = 0;
        m_dout[m]  = RV_TAB[m];
        m_rise[m]  = 4'h0;
        m_fall[m]  = 4'h0;
        m_valid[m] = 1'b0;
        m_value[m] = 4'h0;
        m_mask[m]  = 4'h0;
        m_ovf[m]   = 1'b0;
    endtask

    task automatic model_edge(input int m);
        logic [3:0] chg;
        logic [3:0] nd;
        logic       all_diff;
        logic       hs;
        for (int j = 7; j > 0; j--) hist[m][j] = hist[m][j-1];
        hist[m][0] = din;
        if (hcnt[m] < 8) hcnt[m]++;
        chg = 4'h0;
        for (int b = 0; b < 4; b++) begin
            all_diff = (hcnt[m] >= S_TAB[m]);
            for (int j = 0; j < S_TAB[m]; j++)
                if (hist[m][j][b] == m_dout[m][b]) all_diff = 1'b0;
            chg[b] = all_diff;
        end
        nd = m_dout[m] ^ chg;
        m_rise[m] = chg & din;
        m_fall[m] = chg & ~din;
        hs = m_valid[m] && ready;
        if (chg != 4'h0 && (!m_valid[m] || hs)) begin
            m_valid[m] = 1'b1;
            m_value[m] = nd;
            m_mask[m]  = chg;
            m_ovf[m]   = 1'b0;
        end else if (chg != 4'h0) begin
            m_value[m] = nd;
            m_mask[m]  = m_mask[m] | chg;
            m_ovf[m]   = 1'b1;
        end else if (hs) begin
            m_valid[m] = 1'b0;
            m_mask[m]  = 4'h0;
            m_ovf[m]   = 1'b0;
        end
        m_dout[m] = nd;
    endtask

    task automatic check_inst(input string nm, input int m,
                              input logic [3:0] d, input logic [3:0] r, input logic [3:0] f,
                              input logic v, input logic [3:0] val, input logic [3:0] msk,
                              input logic o);
        chk({nm, ".dout"},  d,   m_dout[m]);
        chk({nm, ".rise"},  r,   m_rise[m]);
        chk({nm, ".fall"},  f,   m_fall[m]);
        chk({nm, ".valid"}, {3'b0, v}, {3'b0, m_valid[m]});
        chk({nm, ".value"}, val, m_value[m]);
        chk({nm, ".mask"},  msk, m_mask[m]);
        chk({nm, ".ovf"},   {3'b0, o}, {3'b0, m_ovf[m]});
    endtask

    task automatic check_all(input string tag);
        check_inst({tag, ":s8"}, 0, o8_dout, o8_rise, o8_fall, o8_valid, o8_value, o8_mask, o8_ovf);
        check_inst({tag, ":s1"}, 1, o1_dout, o1_rise, o1_fall, o1_valid, o1_value, o1_mask, o1_ovf);
        check_inst({tag, ":sa"}, 2, oa_dout, oa_rise, oa_fall, oa_valid, oa_value, oa_mask, oa_ovf);
    endtask

    // Driver: advance n clocks, step the model, check 1 time unit later.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (!rst) for (int m = 0; m < NI; m++) model_edge(m);
            #1;
            if (o8_rise[0]) rise0_cnt++;
            check_all("tick");
        end
    endtask

    // Driver: assert reset between edges and check outputs before any edge.
    task automatic reset_mid();
        #2 rst = 1'b1;
        for (int m = 0; m < NI; m++) model_reset(m);
        #1;
        check_all("rst_async");
    endtask

    // Driver: hold reset across one edge, then release between edges.
    task automatic reset_release();
        @(posedge clk);
        #1;
        check_all("rst_held");
        #2 rst = 1'b0;
    endtask

    task automatic settle(input logic [3:0] v);
        din = v;
        ready = 1'b1;
        tick(10);
        ready = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [3:0] din_prev;
        for (int m = 0; m < NI; m++) model_reset(m);

        // Power-on: asynchronous reset asserted between edges.
        #2 rst = 1'b1;
        #1;
        check_all("por");
        chk("por_dout_a", oa_dout, 4'hA);
        chk("por_dout_0", o8_dout, 4'h0);
        @(posedge clk);
        #3 rst = 1'b0;

        // Basic qualification on bit 0.
        din = 4'h1;
        tick(7);
        chk("basic_hold7", o8_dout, 4'h0);
        tick(1);
        chk("basic_dout",  o8_dout,  4'h1);
        chk("basic_rise",  o8_rise,  4'h1);
        chk("basic_valid", {3'b0, o8_valid}, 4'h1);
        chk("basic_value", o8_value, 4'h1);
        chk("basic_mask",  o8_mask,  4'h1);
        tick(1);
        chk("basic_rise_done", o8_rise, 4'h0);

        // Glitch rejection: 7 high, 1 low, 8 high.
        settle(4'h0);
        rise0_cnt = 0;
        din = 4'h1;
        tick(7);
        chk("glitch_first7", o8_dout, 4'h0);
        din = 4'h0;
        tick(1);
        din = 4'h1;
        tick(7);
        chk("glitch_second7", o8_dout, 4'h0);
        tick(1);
        chk("glitch_accept", o8_dout, 4'h1);
        tick(2);
        chk("glitch_one_rise", 4'(rise0_cnt), 4'h1);

        // Backpressure merge.
        settle(4'h0);
        din = 4'h1;
        tick(8);
        chk("merge_first_mask", o8_mask, 4'h1);
        tick(12);
        din = 4'h5;
        tick(8);
        chk("merge_mask",  o8_mask,  4'h5);
        chk("merge_value", o8_value, 4'h5);
        chk("merge_ovf",   {3'b0, o8_ovf}, 4'h1);
        ready = 1'b1;
        tick(1);
        chk("merge_drain_valid", {3'b0, o8_valid}, 4'h0);
        chk("merge_drain_ovf",   {3'b0, o8_ovf},   4'h0);
        ready = 1'b0;

        // Handshake on the same edge a new change qualifies.
        din = 4'hD;
        tick(4);
        din = 4'hF;
        tick(7);
        chk("simul_pending_mask", o8_mask, 4'h8);
        ready = 1'b1;
        tick(1);
        chk("simul_valid", {3'b0, o8_valid}, 4'h1);
        chk("simul_mask",  o8_mask,  4'h2);
        chk("simul_value", o8_value, 4'hF);
        chk("simul_ovf",   {3'b0, o8_ovf}, 4'h0);
        ready = 1'b0;

        // Reset at count 5, then a fresh 8 cycles are required.
        settle(4'h0);
        din = 4'h1;
        tick(5);
        reset_mid();
        chk("midrst_dout_a", oa_dout, 4'hA);
        chk("midrst_dout_0", o8_dout, 4'h0);
        reset_release();
        tick(7);
        chk("midrst_hold7", o8_dout, 4'h0);
        tick(1);
        chk("midrst_accept", o8_dout, 4'h1);

        // Random phase with occasional reset pulses.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_mid();
                reset_release();
                continue;
            end
            if ($urandom_range(0, 5) == 0) din = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 2) != 0);
            din_prev = din;
            tick(1);
            chk("s1_track", o1_dout, din_prev);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
